// File: rtl/l1_i_data_array_nway.sv
// l1_i_data_array_nway: N-way set-associative L1 instruction-cache data array.
// A line is refilled from L2 as BEATS beats over a valid/ready handshake, starting
// at any beat and wrapping modulo BEATS. Reads return one word one cycle after accept.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_req/rd_index/rd_offset/rd_way   read request, set, byte offset, hit way
//   rd_ready                 read accepted this cycle (combinational)
//   read_data_L1_C/rd_valid  registered read word and its 1-cycle valid
//   refill_start/_index/_way/_first_beat   start refill of one line
//   read_data_L2_L1, refill_beat_valid/ready   refill beat handshake
//   refill_busy/done/err     refill status (err is sticky until reset)
module l1_i_data_array_nway #(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned INUM      = 5,
    parameter int unsigned LINE_BITS = 512,
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned L21BUS    = 128,
    parameter int unsigned OFFW      = 6,
    parameter int unsigned WW        = 2,
    parameter int unsigned BW        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req,
    input  logic [INUM-1:0]      rd_index,
    input  logic [OFFW-1:0]      rd_offset,
    input  logic [WW-1:0]        rd_way,
    output logic                 rd_ready,
    output logic [WORD_BITS-1:0] read_data_L1_C,
    output logic                 rd_valid,
    input  logic                 refill_start,
    input  logic [INUM-1:0]      refill_index,
    input  logic [WW-1:0]        refill_way,
    input  logic [BW-1:0]        refill_first_beat,
    input  logic [L21BUS-1:0]    read_data_L2_L1,
    input  logic                 refill_beat_valid,
    output logic                 refill_beat_ready,
    output logic                 refill_busy,
    output logic                 refill_done,
    output logic                 refill_err
);

    localparam int unsigned SETS  = 1 << INUM;
    localparam int unsigned BEATS = LINE_BITS / L21BUS;
    localparam int unsigned LINES = WAYS * SETS;
    localparam int unsigned AW    = WW + INUM;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

    state_e                state_q, state_d;
    logic [INUM-1:0]       idx_q, idx_d;
    logic [WW-1:0]         way_q, way_d;
    logic [BW-1:0]         first_q, first_d;
    logic [BW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  beat_ready_q, beat_ready_d;
    logic                  done_q, done_d;
    logic [WORD_BITS-1:0]  rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic                  beat_fire;
    logic                  rd_fire;
    logic [BW-1:0]         seg;
    logic [WORD_BITS-1:0]  rd_word;
    logic                  unused_offset_lsb;

    // Data storage; deliberately not reset.
    logic [LINE_BITS-1:0]  mem [LINES];

    // Byte-lane bits are don't-care: reads are word-aligned.
    assign unused_offset_lsb = ^rd_offset[1:0];

    assign rd_ready          = !(busy_q && (rd_index == idx_q) && (rd_way == way_q));
    assign rd_fire           = rd_req && rd_ready;
    assign beat_fire         = refill_beat_valid && beat_ready_q;
    // Destination segment wraps modulo BEATS (BEATS is a power of two).
    assign seg               = BW'(first_q + cnt_q) & BEAT_LAST;
    assign rd_word           = mem[{rd_way, rd_index}][rd_offset[OFFW-1:2] * WORD_BITS +: WORD_BITS];

    assign read_data_L1_C    = rdata_q;
    assign rd_valid          = rvalid_q;
    assign refill_beat_ready = beat_ready_q;
    assign refill_busy       = busy_q;
    assign refill_done       = done_q;
    assign refill_err        = err_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        way_d    = way_q;
        first_d  = first_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (refill_start) begin
                    idx_d   = refill_index;
                    way_d   = refill_way;
                    first_d = refill_first_beat & BEAT_LAST;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (refill_start) begin
                    err_d = 1'b1;
                end
                if (beat_fire) begin
                    cnt_d = BW'(cnt_q + 1'b1);
                    if (cnt_q == BEAT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A new start here chains straight into the next fill.
                if (refill_start) begin
                    idx_d   = refill_index;
                    way_d   = refill_way;
                    first_d = refill_first_beat & BEAT_LAST;
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE);
        beat_ready_d = (state_d == FILL);
        done_d       = (state_d == DONE);

        if (rd_fire) begin
            rdata_d  = rd_word;
            rvalid_d = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            way_q        <= '0;
            first_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            beat_ready_q <= 1'b0;
            done_q       <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            way_q        <= way_d;
            first_q      <= first_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            beat_ready_q <= beat_ready_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // Beat write into the latched line.
    always_ff @(posedge clk) begin
        if (!rst && beat_fire) begin
            mem[{way_q, idx_q}][seg * L21BUS +: L21BUS] <= read_data_L2_L1;
        end
    end

endmodule

// File: tb/tb_l1_i_data_array_nway.sv
// tb_l1_i_data_array_nway: directed self-checking bench for l1_i_data_array_nway
// (default parameters: 4 ways, 32 sets, 512-bit lines, 128-bit beats).
module tb_l1_i_data_array_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req;
    logic [4:0]   rd_index;
    logic [5:0]   rd_offset;
    logic [1:0]   rd_way;
    logic         rd_ready;
    logic [31:0]  read_data_L1_C;
    logic         rd_valid;
    logic         refill_start;
    logic [4:0]   refill_index;
    logic [1:0]   refill_way;
    logic [1:0]   refill_first_beat;
    logic [127:0] read_data_L2_L1;
    logic         refill_beat_valid;
    logic         refill_beat_ready;
    logic         refill_busy;
    logic         refill_done;
    logic         refill_err;

    int errors = 0;
    int checks = 0;

    logic [511:0] model [128];
    logic [1:0]   firsts [128];
    int           order [2048];

    l1_i_data_array_nway dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_index(rd_index), .rd_offset(rd_offset), .rd_way(rd_way),
        .rd_ready(rd_ready), .read_data_L1_C(read_data_L1_C), .rd_valid(rd_valid),
        .refill_start(refill_start), .refill_index(refill_index), .refill_way(refill_way),
        .refill_first_beat(refill_first_beat), .read_data_L2_L1(read_data_L2_L1),
        .refill_beat_valid(refill_beat_valid), .refill_beat_ready(refill_beat_ready),
        .refill_busy(refill_busy), .refill_done(refill_done), .refill_err(refill_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_refill(input logic [4:0] idx, input logic [1:0] way, input logic [1:0] first);
        refill_start      = 1'b1;
        refill_index      = idx;
        refill_way        = way;
        refill_first_beat = first;
        tick();
        refill_start = 1'b0;
    endtask

    // Waits (bounded) for beat_ready, then presents one beat for one cycle.
    task automatic send_beat(input logic [127:0] data, input int gap);
        refill_beat_valid = 1'b0;
        repeat (gap) tick();
        for (int i = 0; i < 20 && !refill_beat_ready; i++) tick();
        check("beat_ready", refill_beat_ready, 1);
        refill_beat_valid = 1'b1;
        read_data_L2_L1   = data;
        tick();
        refill_beat_valid = 1'b0;
    endtask

    // Issues one read; leaves rd_req asserted so back-to-back reads chain.
    task automatic do_read(input string tag, input logic [4:0] idx, input logic [1:0] way,
                           input logic [5:0] off, input logic [31:0] exp);
        rd_req    = 1'b1;
        rd_index  = idx;
        rd_way    = way;
        rd_offset = off;
        #1;
        check({tag, "_ready"}, rd_ready, 1);
        tick();
        check({tag, "_valid"}, rd_valid, 1);
        check(tag, read_data_L1_C, exp);
    endtask

    initial begin
        rst = 1'b1; rd_req = 0; rd_index = 0; rd_offset = 0; rd_way = 0;
        refill_start = 0; refill_index = 0; refill_way = 0; refill_first_beat = 0;
        read_data_L2_L1 = '0; refill_beat_valid = 0;

        // Reset with random inputs: every output held low.
        for (int c = 0; c < 5; c++) begin
            rd_req = 1'($urandom); rd_index = 5'($urandom); rd_offset = 6'($urandom);
            rd_way = 2'($urandom); refill_start = 1'($urandom); refill_index = 5'($urandom);
            refill_way = 2'($urandom); refill_first_beat = 2'($urandom);
            read_data_L2_L1 = {4{$urandom}}; refill_beat_valid = 1'($urandom);
            tick();
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rdata", read_data_L1_C, 0);
            check("rst_busy", refill_busy, 0);
            check("rst_bready", refill_beat_ready, 0);
            check("rst_done", refill_done, 0);
            check("rst_err", refill_err, 0);
        end
        rst = 0; rd_req = 0; refill_start = 0; refill_beat_valid = 0;
        tick();

        // In-order refill: set 5, way 2, beat k word j = A00000kj.
        start_refill(5'd5, 2'd2, 2'd0);
        check("fill_busy", refill_busy, 1);
        send_beat(128'hA0000003_A0000002_A0000001_A0000000, 0);
        send_beat(128'hA0000013_A0000012_A0000011_A0000010, 0);
        send_beat(128'hA0000023_A0000022_A0000021_A0000020, 0);
        check("no_early_done", refill_done, 0);
        send_beat(128'hA0000033_A0000032_A0000031_A0000030, 0);
        check("done_pulse", refill_done, 1);
        check("done_bready", refill_beat_ready, 0);
        tick();
        check("done_clear", refill_done, 0);
        check("idle_busy", refill_busy, 0);
        do_read("rd_a_w4", 5'd5, 2'd2, 6'h10, 32'hA0000010);
        do_read("rd_a_lsb", 5'd5, 2'd2, 6'h2F, 32'hA0000023);
        rd_req = 0;
        tick();
        check("rd_valid_pulse", rd_valid, 0);
        check("rdata_hold", read_data_L1_C, 32'hA0000023);

        // Wrap-around: set 6, way 1, first beat 3 -> D0 in seg 3, D1 in seg 0.
        start_refill(5'd6, 2'd1, 2'd3);
        send_beat(128'hD0000003_D0000002_D0000001_D0000000, 0);
        send_beat(128'hD0000013_D0000012_D0000011_D0000010, 0);
        send_beat(128'hD0000023_D0000022_D0000021_D0000020, 0);
        send_beat(128'hD0000033_D0000032_D0000031_D0000030, 0);
        check("wrap_done", refill_done, 1);
        tick();
        do_read("rd_d_off00", 5'd6, 2'd1, 6'h00, 32'hD0000010);
        do_read("rd_d_off3c", 5'd6, 2'd1, 6'h3C, 32'hD0000003);
        do_read("rd_d_off18", 5'd6, 2'd1, 6'h18, 32'hD0000022);
        rd_req = 0;

        // Back-pressure and blocking: refill set 6 way 0 (first 1) with gaps.
        start_refill(5'd6, 2'd0, 2'd1);
        rd_req = 1; rd_index = 5'd6; rd_way = 2'd0; rd_offset = 6'h00;
        #1;
        check("blk_ready", rd_ready, 0);
        tick();
        check("blk_no_valid", rd_valid, 0);
        do_read("rd_other_way", 5'd6, 2'd1, 6'h00, 32'hD0000010);
        rd_req = 0;
        send_beat(128'hE0000003_E0000002_E0000001_E0000000, 3);
        check("gap_busy", refill_busy, 1);
        send_beat(128'hE0000013_E0000012_E0000011_E0000010, 3);
        send_beat(128'hE0000023_E0000022_E0000021_E0000020, 3);
        send_beat(128'hE0000033_E0000032_E0000031_E0000030, 3);
        check("gap_done", refill_done, 1);
        tick();
        do_read("rd_e_off00", 5'd6, 2'd0, 6'h00, 32'hE0000030);
        do_read("rd_e_off14", 5'd6, 2'd0, 6'h14, 32'hE0000001);
        rd_req = 0;

        // Start during FILL: sticky error, latched line unchanged; then reset mid-fill.
        start_refill(5'd7, 2'd3, 2'd0);
        start_refill(5'd8, 2'd0, 2'd2);
        check("err_set", refill_err, 1);
        rd_index = 5'd7; rd_way = 2'd3;
        #1;
        check("err_latched_blk", rd_ready, 0);
        rd_index = 5'd8; rd_way = 2'd0;
        #1;
        check("err_new_free", rd_ready, 1);
        send_beat(128'h1, 0);
        send_beat(128'h2, 0);
        check("err_sticky", refill_err, 1);
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst_busy", refill_busy, 0);
        check("mid_rst_err", refill_err, 0);
        check("mid_rst_bready", refill_beat_ready, 0);
        tick();
        check("mid_rst_no_done", refill_done, 0);

        // Fill every line, chaining each start into the DONE cycle of the previous one.
        for (int ln = 0; ln < 128; ln++) firsts[ln] = 2'($urandom);
        start_refill(5'(0), 2'(0), firsts[0]);
        for (int ln = 0; ln < 128; ln++) begin
            for (int k = 0; k < 4; k++) begin
                logic [127:0] d;
                int seg;
                d   = {$urandom, $urandom, $urandom, $urandom};
                seg = (int'(firsts[ln]) + k) % 4;
                model[ln][seg*128 +: 128] = d;
                send_beat(d, 0);
            end
            check("all_done", refill_done, 1);
            if (ln < 127) begin
                start_refill(5'((ln + 1) % 32), 2'((ln + 1) / 32), firsts[ln + 1]);
                check("chain_bready", refill_beat_ready, 1);
                check("chain_err", refill_err, 0);
            end else begin
                tick();
            end
        end
        check("all_idle", refill_busy, 0);

        // Read every word of every line in shuffled order.
        for (int i = 0; i < 2048; i++) order[i] = i;
        for (int i = 2047; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 2048; i++) begin
            int ln;
            int w;
            ln = order[i] / 16;
            w  = order[i] % 16;
            do_read("rd_all", 5'(ln % 32), 2'(ln / 32), 6'(w * 4), model[ln][w*32 +: 32]);
        end
        rd_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
